// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared owner encoding and default widths for the ROM arbiter
//
// Purpose: common types and constants imported by rom_arb and its sub-module.
// Contents:
//   AW_DEF, DW_DEF : default address / data widths
//   owner_e        : identity of the requester whose ROM read is in flight
package core_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/rom_arb_starve.sv
// rtl/rom_arb_starve.sv - saturating fetch-starvation counter with promote flag
//
// Purpose: counts consecutive cycles in which fetch requested but was denied.
// Ports:
//   clk      in   core clock
//   rst_n    in   synchronous reset, active-high
//   ifu_req  in   fetch request
//   ifu_gnt  in   fetch granted this cycle
//   promote  out  counter has reached MAX_WAIT; fetch outranks LSU
module rom_arb_starve #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_req,
  input  logic ifu_gnt,
  output logic promote
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // A grant or an idle fetch port ends the starvation run.
    if (!ifu_req || ifu_gnt) begin
      cnt_d = 4'd0;
    end else if (cnt_q != MAX_CNT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote = (cnt_q == MAX_CNT);

endmodule

// File: rtl/rom_arb.sv
// rtl/rom_arb.sv - three-way arbiter for the single-port instruction ROM
//
// Purpose: shares one synchronous-read ROM between fetch, LSU and debug,
// returns read data to the owning requester one cycle after the grant.
// Ports:
//   clk, rst_n                      clock, synchronous active-high reset
//   ifu_req/addr/flush              fetch request, PC, redirect
//   ifu_gnt/stall/rvalid/rdata      fetch grant, PC hold, return data
//   lsu_req/addr, lsu_gnt/rvalid/rdata   load request and return
//   dbg_req/addr, dbg_gnt/rvalid/rdata   debug request and return
//   rom_addr_o, rom_en_o, rom_data_i     ROM port (data valid one cycle after enable)
module rom_arb
  import core_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  input  logic          ifu_flush,
  output logic          ifu_gnt,
  output logic          ifu_stall,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req,
  input  logic [AW-1:0] lsu_addr,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_en_o,
  input  logic [DW-1:0] rom_data_i
);

  owner_e owner_q, owner_d;
  logic   drop_q, drop_d;
  owner_e sel;
  logic   promote;

  rom_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .ifu_req (ifu_req),
    .ifu_gnt (ifu_gnt),
    .promote (promote)
  );

  // Debug always wins; a starved fetch jumps ahead of the LSU only.
  always_comb begin
    sel = OWN_NONE;
    if (!rst_n) begin
      if (dbg_req)                   sel = OWN_DBG;
      else if (promote && ifu_req)   sel = OWN_IFU;
      else if (lsu_req)              sel = OWN_LSU;
      else if (ifu_req)              sel = OWN_IFU;
    end
  end

  assign ifu_gnt   = (sel == OWN_IFU);
  assign lsu_gnt   = (sel == OWN_LSU);
  assign dbg_gnt   = (sel == OWN_DBG);
  assign ifu_stall = ifu_req & ~ifu_gnt & ~rst_n;
  assign rom_en_o  = ifu_gnt | lsu_gnt | dbg_gnt;

  always_comb begin
    rom_addr_o = '0;
    if (ifu_gnt)      rom_addr_o = ifu_addr;
    else if (lsu_gnt) rom_addr_o = lsu_addr;
    else if (dbg_gnt) rom_addr_o = dbg_addr;
  end

  always_comb begin
    owner_d = sel;
    // Redirect in the grant cycle: remember to swallow next cycle's data.
    drop_d  = ifu_gnt & ifu_flush;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      owner_q <= OWN_NONE;
      drop_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      drop_q  <= drop_d;
    end
  end

  // Returns are masked while reset is asserted so a transfer caught by
  // reset never reaches its requester.
  logic own_ifu, own_lsu, own_dbg;
  assign own_ifu = ~rst_n & (owner_q == OWN_IFU);
  assign own_lsu = ~rst_n & (owner_q == OWN_LSU);
  assign own_dbg = ~rst_n & (owner_q == OWN_DBG);

  assign ifu_rvalid = own_ifu & ~drop_q & ~ifu_flush;
  assign lsu_rvalid = own_lsu;
  assign dbg_rvalid = own_dbg;
  assign ifu_rdata  = own_ifu ? rom_data_i : '0;
  assign lsu_rdata  = own_lsu ? rom_data_i : '0;
  assign dbg_rdata  = own_dbg ? rom_data_i : '0;

endmodule
